// File: rtl/dmux_frame_sequencer_if.sv
// Handshake and demux-side signals of the frame sequencer, bundled for port use.
interface dmux_frame_sequencer_if #(
   parameter int unsigned NUM_CH = 8,
   parameter int unsigned SEL_W  = 3
);
   logic              start;
   logic              abort;
   logic [NUM_CH-1:0] ch_mask;
   logic              din;
   logic              din_valid;
   logic              din_ready;
   logic [SEL_W-1:0]  s;
   logic              i;
   logic              out_valid;
   logic              busy;
   logic              frame_done;
   logic              empty_err;

   // Controller side: drives frame requests and serial data.
   modport master (
      output start, abort, ch_mask, din, din_valid,
      input  din_ready, s, i, out_valid, busy, frame_done, empty_err
   );

   // Sequencer side.
   modport slave (
      input  start, abort, ch_mask, din, din_valid,
      output din_ready, s, i, out_valid, busy, frame_done, empty_err
   );
endinterface

// File: rtl/dmux_frame_sequencer.sv
// Frame sequencer for a 1-to-8 demux: delivers one serial bit to each enabled
// channel in ascending order, registering select/data for the demux.
module dmux_frame_sequencer #(
   parameter int unsigned NUM_CH = 8,
   parameter int unsigned SEL_W  = 3
) (
   input logic                   clk,
   input logic                   rst,
   dmux_frame_sequencer_if.slave bus
);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e            state_q, state_d;
   logic [NUM_CH-1:0] mask_q, mask_d;
   logic [SEL_W-1:0]  ch_q, ch_d;
   logic [SEL_W-1:0]  s_q, s_d;
   logic              i_q, i_d;
   logic              out_valid_q, out_valid_d;
   logic              empty_q, empty_d;

   logic [SEL_W-1:0]  first_ch;
   logic [SEL_W-1:0]  next_ch;
   logic              next_found;
   logic              din_ready;
   logic              accept;

   // Priority search: lowest set bit of the incoming mask, and lowest set
   // bit of the latched mask strictly above the current channel.
   always_comb begin
      first_ch   = '0;
      next_ch    = '0;
      next_found = 1'b0;
      for (int n = int'(NUM_CH) - 1; n >= 0; n--) begin
         if (bus.ch_mask[n]) begin
            first_ch = SEL_W'(n);
         end
         if (mask_q[n] && (n > int'(ch_q))) begin
            next_ch    = SEL_W'(n);
            next_found = 1'b1;
         end
      end
   end

   assign din_ready = (state_q == StRun);
   assign accept    = bus.din_valid & din_ready;

   // Next-state logic; i/out_valid default low so the demux idles at zero.
   always_comb begin
      state_d     = state_q;
      mask_d      = mask_q;
      ch_d        = ch_q;
      s_d         = s_q;
      i_d         = 1'b0;
      out_valid_d = 1'b0;
      empty_d     = empty_q;
      case (state_q)
         StIdle: begin
            if (bus.start) begin
               mask_d = bus.ch_mask;
               if (|bus.ch_mask) begin
                  ch_d    = first_ch;
                  empty_d = 1'b0;
                  state_d = StRun;
               end else begin
                  empty_d = 1'b1;
                  state_d = StDone;
               end
            end
         end
         StRun: begin
            // Abort wins over a same-cycle accept; that beat is dropped.
            if (bus.abort) begin
               state_d = StIdle;
            end else if (accept) begin
               s_d         = ch_q;
               i_d         = bus.din;
               out_valid_d = 1'b1;
               if (next_found) begin
                  ch_d = next_ch;
               end else begin
                  state_d = StDone;
               end
            end
         end
         StDone: begin
            empty_d = 1'b0;
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         mask_q      <= '0;
         ch_q        <= '0;
         s_q         <= '0;
         i_q         <= 1'b0;
         out_valid_q <= 1'b0;
         empty_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         mask_q      <= mask_d;
         ch_q        <= ch_d;
         s_q         <= s_d;
         i_q         <= i_d;
         out_valid_q <= out_valid_d;
         empty_q     <= empty_d;
      end
   end

   assign bus.din_ready  = din_ready;
   assign bus.s          = s_q;
   assign bus.i          = i_q;
   assign bus.out_valid  = out_valid_q;
   assign bus.busy       = (state_q != StIdle);
   assign bus.frame_done = (state_q == StDone);
   assign bus.empty_err  = (state_q == StDone) & empty_q;

endmodule

// File: tb/tb_dmux_frame_sequencer.sv
// Self-checking bench: table of frames plus a hand-written mid-frame reset,
// with expected deliveries queued as data is driven and popped on out_valid.
module tb_dmux_frame_sequencer;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   dmux_frame_sequencer_if bus ();

   dmux_frame_sequencer u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic [2:0] s;
      logic       i;
      logic       last;
   } exp_t;

   // bits: data in delivery order (bit 0 first); vpat: din_valid per RUN cycle.
   typedef struct {
      logic [7:0]  mask;
      logic [7:0]  bits;
      logic [15:0] vpat;
      int          abort_at;
      logic        poke_start;
      int          n_del;
   } vec_t;

   exp_t q[$];
   int   nchk = 0;
   int   nerr = 0;
   int   ndel;
   logic exp_empty = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_outputs();
      exp_t e;
      if (bus.out_valid === 1'b1) begin
         ndel++;
         chk("delivery_was_expected", 32'(q.size() != 0), 1);
         if (q.size() != 0) begin
            e = q.pop_front();
            chk("s", bus.s, e.s);
            chk("i", bus.i, e.i);
            chk("frame_done_on_delivery", bus.frame_done, e.last);
            chk("empty_err_on_delivery", bus.empty_err, 0);
         end
      end else begin
         chk("out_valid_low", bus.out_valid, 0);
         chk("i_zero_when_idle", bus.i, 0);
         chk("frame_done", bus.frame_done, exp_empty);
         chk("empty_err", bus.empty_err, exp_empty);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      check_outputs();
   endtask

   task automatic run_frame(input vec_t v);
      int   chs[$];
      int   idx;
      int   cyc;
      logic aborted;
      for (int n = 0; n < 8; n++) if (v.mask[n]) chs.push_back(n);
      ndel          = 0;
      bus.ch_mask   = v.mask;
      bus.start     = 1'b1;
      exp_empty     = (chs.size() == 0);
      tick();
      bus.start     = 1'b0;
      bus.ch_mask   = ~v.mask;  // must be ignored while busy
      chk("busy_after_start", bus.busy, 1);
      if (chs.size() == 0) begin
         chk("din_ready_empty", bus.din_ready, 0);
         exp_empty = 1'b0;
         tick();
         chk("busy_after_empty", bus.busy, 0);
         chk("din_ready_after_empty", bus.din_ready, 0);
      end else begin
         idx     = 0;
         cyc     = 0;
         aborted = 1'b0;
         while (idx < chs.size() && cyc < 16 && !aborted) begin
            chk("din_ready_run", bus.din_ready, 1);
            bus.din_valid = v.vpat[cyc];
            bus.din       = v.bits[idx];
            bus.start     = v.poke_start && (cyc == 1);
            if (idx == v.abort_at) begin
               bus.abort     = 1'b1;
               bus.din_valid = 1'b1;
               aborted       = 1'b1;
            end else if (bus.din_valid) begin
               q.push_back(exp_t'{s: 3'(chs[idx]), i: v.bits[idx],
                                  last: (idx == chs.size() - 1)});
               idx++;
            end
            cyc++;
            tick();
            bus.abort     = 1'b0;
            bus.start     = 1'b0;
            bus.din_valid = 1'b0;
            bus.din       = 1'b1;
         end
         if (aborted) begin
            chk("din_ready_after_abort", bus.din_ready, 0);
            chk("busy_after_abort", bus.busy, 0);
            tick();
            chk("busy_idle_after_abort", bus.busy, 0);
         end else begin
            chk("frame_within_budget", idx, chs.size());
            chk("busy_in_done", bus.busy, 1);
            chk("din_ready_in_done", bus.din_ready, 0);
            tick();
            chk("busy_after_done", bus.busy, 0);
            chk("din_ready_after_done", bus.din_ready, 0);
         end
      end
      chk("deliveries", ndel, v.n_del);
      chk("queue_drained", q.size(), 0);
      q.delete();
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_s"}, bus.s, 0);
      chk({tag, "_i"}, bus.i, 0);
      chk({tag, "_out_valid"}, bus.out_valid, 0);
      chk({tag, "_din_ready"}, bus.din_ready, 0);
      chk({tag, "_busy"}, bus.busy, 0);
      chk({tag, "_frame_done"}, bus.frame_done, 0);
      chk({tag, "_empty_err"}, bus.empty_err, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs[7];
      vec_t v;
      vecs[0] = '{mask: 8'hFF, bits: 8'b0100_1101, vpat: 16'hFFFF, abort_at: -1,
                  poke_start: 1'b0, n_del: 8};
      vecs[1] = '{mask: 8'b1010_0100, bits: 8'b0000_0111, vpat: 16'hFFFF, abort_at: -1,
                  poke_start: 1'b0, n_del: 3};
      vecs[2] = '{mask: 8'h0F, bits: 8'b0000_1101, vpat: 16'h0059, abort_at: -1,
                  poke_start: 1'b0, n_del: 4};
      vecs[3] = '{mask: 8'h00, bits: 8'h00, vpat: 16'hFFFF, abort_at: -1,
                  poke_start: 1'b0, n_del: 0};
      vecs[4] = '{mask: 8'hFF, bits: 8'b1111_1111, vpat: 16'hFFFF, abort_at: 3,
                  poke_start: 1'b0, n_del: 3};
      vecs[5] = '{mask: 8'hFF, bits: 8'b1010_0110, vpat: 16'hFFFF, abort_at: -1,
                  poke_start: 1'b1, n_del: 8};
      vecs[6] = '{mask: 8'h81, bits: 8'b0000_0010, vpat: 16'hAAAA, abort_at: -1,
                  poke_start: 1'b0, n_del: 2};

      rst           = 1'b1;
      bus.start     = 1'b0;
      bus.abort     = 1'b0;
      bus.ch_mask   = 8'h00;
      bus.din       = 1'b0;
      bus.din_valid = 1'b0;
      #1;
      check_all_zero("reset");
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      foreach (vecs[k]) run_frame(vecs[k]);

      // Reset mid-frame, just after channel 4 has been delivered.
      ndel        = 0;
      bus.ch_mask = 8'hFF;
      bus.start   = 1'b1;
      tick();
      bus.start   = 1'b0;
      for (int n = 0; n < 5; n++) begin
         bus.din_valid = 1'b1;
         bus.din       = n[0];
         q.push_back(exp_t'{s: 3'(n), i: n[0], last: 1'b0});
         tick();
      end
      bus.din_valid = 1'b0;
      tick();
      chk("mid_frame_deliveries", ndel, 5);
      chk("mid_frame_busy", bus.busy, 1);
      rst = 1'b1;
      #1;
      check_all_zero("async_reset");
      @(posedge clk);
      #1;
      check_all_zero("held_reset");
      rst = 1'b0;
      q.delete();

      v = '{mask: 8'h01, bits: 8'b0000_0001, vpat: 16'hFFFF, abort_at: -1,
            poke_start: 1'b0, n_del: 1};
      run_frame(v);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule

// File: doc/dmux_frame_sequencer.md
# dmux_frame_sequencer

Upstream driver for the 1-to-8 demultiplexer. Accepts a frame of serial data bits over a valid/ready handshake and presents each bit on the demux data input with the matching 3-bit select. Channels are visited in ascending order, and masked-off channels are skipped. A frame completes after the highest enabled channel has received its bit.

## Interface
- NUM_CH, 8: number of demux outputs; fixed at 8.
- SEL_W, 3: select width, log2(NUM_CH).
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to begin a frame; honoured only in IDLE.
- abort  in  1  synchronous frame abort; honoured only in RUN.
- ch_mask  in  8  per-channel enable; bit n enables channel n; sampled when start is honoured.
- din  in  1  serial data bit.
- din_valid  in  1  din is valid this cycle.
- din_ready  out  1  sequencer accepts din this cycle.
- s  out  SEL_W  demux select, registered.
- i  out  1  demux data input, registered.
- out_valid  out  1  s/i carry a delivered bit this cycle.
- busy  out  1  high in RUN and DONE.
- frame_done  out  1  one-cycle pulse at frame end.
- empty_err  out  1  one-cycle pulse when a frame starts with ch_mask == 0.

## Operation
- State machine: IDLE, RUN, DONE. The mask register (8 bits) and the current-channel register (SEL_W bits) are internal.
- IDLE:
  - On start: latch ch_mask.
  - If the latched mask is non-zero: current channel = lowest set bit; go to RUN.
  - If the latched mask is zero: go to DONE with empty_err.
- RUN:
  - din_ready = 1, decoded combinationally from the state.
  - Accept = din_valid & din_ready.
  - On accept, next cycle: s = current channel, i = din, out_valid = 1. The current channel advances to the next set mask bit above it.
  - If no set bit remains above the current channel: go to DONE.
  - With no accept, the state holds and i = 0, out_valid = 0.
- DONE:
  - Lasts exactly one cycle: frame_done = 1, then IDLE.
  - empty_err = 1 only if the frame was entered with a zero mask.
- abort in RUN: go to IDLE next cycle. No frame_done; the remaining channels receive nothing.
- Priority rules:
  - abort wins over an accept in the same cycle; the beat is not delivered.
  - start outside IDLE is ignored.
  - ch_mask changes outside IDLE are ignored.
- i is forced to 0 whenever out_valid = 0, so every demux output stays low between deliveries.
- s holds its last value when out_valid = 0.
- Only enabled channels ever appear on s with out_valid = 1. Each enabled channel appears exactly once per completed frame, in strictly ascending order.

## Timing
- Reset (asynchronous, immediate): state = IDLE, mask = 0, channel = 0, s = 0, i = 0, out_valid = 0, din_ready = 0, busy = 0, frame_done = 0, empty_err = 0.
- A reset asserted mid-frame discards the frame with no frame_done.
- start honoured at cycle t: busy and din_ready are high from t+1.
- Zero mask: DONE is at t+1 with frame_done = empty_err = 1; IDLE at t+2.
- Latency is 1 cycle from accepted din to s/i/out_valid.
- Throughput is 1 bit per cycle while din_valid is held high.
- Last accept at cycle k:
  - out_valid at k+1, in the same cycle as DONE/frame_done.
  - IDLE and busy = 0 at k+2.
  - A new start is honoured at k+2 at the earliest.
- Full mask with din_valid held high: 8 consecutive deliveries with s = 0..7 at t+2..t+9. frame_done at t+9. din_ready is high for exactly 8 cycles, t+1..t+8.
- abort at cycle a in RUN: IDLE and din_ready = 0 at a+1; no out_valid at a+1.

## Test plan
- Full frame: reset, ch_mask = 8'hFF, start, din = 1,0,1,1,0,0,1,0 with din_valid held high -> s = 0..7 on consecutive cycles; i matches din; frame_done once, in the cycle with s = 7.
- Sparse mask: ch_mask = 8'b1010_0100, din = 1,1,1 -> deliveries only on s = 2, 5, 7; frame_done with the s = 7 delivery; channels 0, 1, 3, 4, 6 never selected.
- Stalls: ch_mask = 8'h0F, din_valid toggled 1,0,0,1,1,0,1 -> exactly 4 deliveries, s = 0..3 in order; i = 0 and out_valid = 0 in stall cycles.
- Empty mask: ch_mask = 0, start -> next cycle frame_done = empty_err = 1, din_ready never high, out_valid never high.
- Abort and ignored start: ch_mask = 8'hFF, abort after 3 deliveries -> IDLE, no frame_done. A start pulsed while busy during a subsequent frame is ignored and that frame completes normally.
- Reset mid-frame: assert rst after delivery to channel 4 -> all outputs immediately 0, state IDLE. A fresh frame with ch_mask = 8'h01 then delivers only s = 0.
